// File: rtl/c3lib_skid_buf.sv
// Two-entry ready/valid skid buffer: registered forward data/valid and registered
// reverse ready, one cycle of latency, full throughput, synchronous flush.
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | nothing buffered; out_vld=0, in_rdy=1 (0 only in reset cycle)
// BUSY  | main holds one word; out_vld=1, in_rdy=1
// FULL  | main and skid both hold a word; out_vld=1, in_rdy=0
module c3lib_skid_buf #(
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_vld,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_rdy,
   output logic              out_vld,
   output logic [DWIDTH-1:0] out_data,
   input  logic              out_rdy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   logic [DWIDTH-1:0] main_q;
   logic [DWIDTH-1:0] skid_q;
   logic              acc;
   logic              pop;

   assign acc      = in_vld & in_rdy;
   assign pop      = out_vld & out_rdy;
   assign out_data = main_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= EMPTY;
         out_vld <= 1'b0;
         in_rdy  <= 1'b0;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (flush) begin
         // A pop on this cycle already completed; an acc is simply dropped.
         state   <= EMPTY;
         out_vld <= 1'b0;
         in_rdy  <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               in_rdy <= 1'b1;
               if (acc) begin
                  main_q  <= in_data;
                  out_vld <= 1'b1;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (acc && pop) begin
                  main_q <= in_data;
               end else if (acc) begin
                  skid_q <= in_data;
                  in_rdy <= 1'b0;
                  state  <= FULL;
               end else if (pop) begin
                  out_vld <= 1'b0;
                  state   <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  main_q <= skid_q;
                  in_rdy <= 1'b1;
                  state  <= BUSY;
               end
            end
            default: begin
               state   <= EMPTY;
               out_vld <= 1'b0;
               in_rdy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_c3lib_skid_buf.sv
// Directed and random-backpressure bench for c3lib_skid_buf.
module tb_c3lib_skid_buf;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       in_vld;
   logic [7:0] in_data;
   logic       in_rdy;
   logic       out_vld;
   logic [7:0] out_data;
   logic       out_rdy;

   int checks = 0;
   int errors = 0;

   c3lib_skid_buf #(.DWIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_vld   (in_vld),
      .in_data  (in_data),
      .in_rdy   (in_rdy),
      .out_vld  (out_vld),
      .out_data (out_data),
      .out_rdy  (out_rdy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      in_vld  = 1'b1;
      in_data = d;
      tick();
      in_vld  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_vld = 1'b1; in_data = 8'hEE; out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_vld !== 1'b0 || in_rdy !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset cyc%0d: out_vld=%b in_rdy=%b out_data=%h, need 0 0 00",
                     i, out_vld, in_rdy, out_data);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_rdy=%b out_vld=%b, need 1 0", in_rdy, out_vld);
      end
      in_vld = 1'b0;
   endtask

   task automatic test_stream();
      out_rdy = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_vld  = 1'b1;
         in_data = 8'(i);
         tick();
         checks++;
         if (out_vld !== 1'b1 || out_data !== 8'(i) || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL stream word%0d: out_vld=%b out_data=%h in_rdy=%b, need 1 %h 1",
                     i, out_vld, out_data, in_rdy, 8'(i));
         end
      end
      in_vld = 1'b0;
      tick();
      checks++;
      if (out_vld !== 1'b0) begin
         errors++;
         $display("FAIL stream_drain: out_vld=%b, need 0", out_vld);
      end
   endtask

   task automatic test_skid();
      out_rdy = 1'b0;
      in_vld = 1'b1; in_data = 8'hA1;
      tick();
      checks++;
      if (out_vld !== 1'b1 || out_data !== 8'hA1 || in_rdy !== 1'b1) begin
         errors++;
         $display("FAIL skid_busy: out_vld=%b out_data=%h in_rdy=%b, need 1 a1 1",
                  out_vld, out_data, in_rdy);
      end
      in_data = 8'hA2;
      tick();
      checks++;
      if (out_vld !== 1'b1 || out_data !== 8'hA1 || in_rdy !== 1'b0) begin
         errors++;
         $display("FAIL skid_full: out_vld=%b out_data=%h in_rdy=%b, need 1 a1 0",
                  out_vld, out_data, in_rdy);
      end
      in_data = 8'hA3;
      tick();
      checks++;
      if (out_vld !== 1'b1 || out_data !== 8'hA1 || in_rdy !== 1'b0) begin
         errors++;
         $display("FAIL skid_hold: out_vld=%b out_data=%h in_rdy=%b, need 1 a1 0",
                  out_vld, out_data, in_rdy);
      end
      out_rdy = 1'b1;
      tick();
      checks++;
      if (out_vld !== 1'b1 || out_data !== 8'hA2 || in_rdy !== 1'b1) begin
         errors++;
         $display("FAIL skid_recover: out_vld=%b out_data=%h in_rdy=%b, need 1 a2 1",
                  out_vld, out_data, in_rdy);
      end
      tick();
      checks++;
      if (out_vld !== 1'b1 || out_data !== 8'hA3) begin
         errors++;
         $display("FAIL skid_a3: out_vld=%b out_data=%h, need 1 a3", out_vld, out_data);
      end
      in_vld = 1'b0;
      tick();
      checks++;
      if (out_vld !== 1'b0) begin
         errors++;
         $display("FAIL skid_drain: out_vld=%b, need 0", out_vld);
      end
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      logic       m_acc, m_pop, exp_rdy;
      int         nfail = 0;
      for (int c = 0; c < 10000; c++) begin
         in_vld  = 1'($urandom_range(0, 1));
         out_rdy = 1'($urandom_range(0, 1));
         in_data = 8'($urandom);
         exp_rdy = (q.size() < 2);
         m_acc   = in_vld & exp_rdy;
         m_pop   = (q.size() > 0) & out_rdy;
         tick();
         if (m_pop) void'(q.pop_front());
         if (m_acc) q.push_back(in_data);
         checks++;
         if (q.size() > 2 || in_rdy !== (q.size() < 2) || out_vld !== (q.size() > 0) ||
             (q.size() > 0 && out_data !== q[0])) begin
            errors++;
            nfail++;
            if (nfail <= 10)
               $display("FAIL random cyc%0d: out_vld=%b in_rdy=%b out_data=%h, need vld=%b rdy=%b data=%h",
                        c, out_vld, in_rdy, out_data, q.size() > 0, q.size() < 2,
                        (q.size() > 0) ? q[0] : 8'h00);
         end
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_flush();
      out_rdy = 1'b0;
      push(8'h11);
      push(8'h22);
      flush = 1'b1; in_vld = 1'b1; in_data = 8'h55;
      tick();
      flush = 1'b0; in_vld = 1'b0;
      checks++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
         errors++;
         $display("FAIL flush_full: out_vld=%b in_rdy=%b, need 0 1", out_vld, in_rdy);
      end
      // flush in BUSY where the 0x55 handshake actually happens
      push(8'h33);
      flush = 1'b1; in_vld = 1'b1; in_data = 8'h55;
      tick();
      flush = 1'b0; in_vld = 1'b0;
      checks++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
         errors++;
         $display("FAIL flush_busy: out_vld=%b in_rdy=%b, need 0 1", out_vld, in_rdy);
      end
      out_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_vld !== 1'b0) begin
            errors++;
            $display("FAIL flush_after cyc%0d: out_vld=%b out_data=%h, need vld 0",
                     i, out_vld, out_data);
         end
      end
   endtask

   task automatic test_rst_mid();
      out_rdy = 1'b0;
      push(8'h77);
      rst = 1'b1;
      tick();
      checks++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid: out_vld=%b in_rdy=%b out_data=%h, need 0 0 00",
                  out_vld, in_rdy, out_data);
      end
      rst = 1'b0;
      out_rdy = 1'b1;
      tick();
      checks++;
      if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_release: out_vld=%b in_rdy=%b, need 0 1", out_vld, in_rdy);
      end
      push(8'h44);
      rst = 1'b1; flush = 1'b1;
      tick();
      checks++;
      if (in_rdy !== 1'b0 || out_vld !== 1'b0) begin
         errors++;
         $display("FAIL rst_flush: in_rdy=%b out_vld=%b, need 0 0", in_rdy, out_vld);
      end
      rst = 1'b0; flush = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_skid();
      test_random();
      test_flush();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
